// File: rtl/sort_job_arbiter.sv
// Round-robin owner of one shared radix sorter: grants a job, steers the owner's values in,
// returns the sorted stream to that owner only, and releases after the last value is returned.
module sort_job_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int VALUE_WIDTH = 10,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_length_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             job_done_o,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value_i,
    input  logic [NUM_REQ-1:0]             req_value_valid_i,
    output logic [NUM_REQ-1:0]             req_value_ready_o,
    output logic [VALUE_WIDTH-1:0]         res_value_o,
    output logic [NUM_REQ-1:0]             res_valid_o,
    input  logic [NUM_REQ-1:0]             res_ready_i,
    output logic                           srt_start_o,
    output logic [COUNT_WIDTH-1:0]         srt_length_o,
    output logic [VALUE_WIDTH-1:0]         srt_value_o,
    output logic                           srt_value_valid_o,
    input  logic                           srt_value_ready_i,
    input  logic [VALUE_WIDTH-1:0]         srt_sorted_value_i,
    input  logic                           srt_sorted_valid_i,
    output logic                           srt_sorted_ready_o,
    input  logic                           srt_busy_i,
    output logic                           busy_o
);
    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, LOAD, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   rr_q, owner_q, pick, cand, next_ptr;
    logic                   pick_found;
    logic [COUNT_WIDTH-1:0] len_q, in_cnt_q, out_cnt_q, in_cnt_d, out_cnt_d;
    logic                   in_open, out_open;
    logic [NUM_REQ-1:0]     owner_onehot;
    logic [VALUE_WIDTH-1:0] value_arr  [NUM_REQ];
    logic [COUNT_WIDTH-1:0] length_arr [NUM_REQ];
    int                     idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign value_arr[i]  = req_value_i[i*VALUE_WIDTH +: VALUE_WIDTH];
        assign length_arr[i] = req_length_i[i*COUNT_WIDTH +: COUNT_WIDTH];
    end

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pick       = rr_q;
        pick_found = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_WIDTH'(idx);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
    end

    assign next_ptr = (owner_q == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign in_open  = (in_cnt_q < len_q);
    assign out_open = (out_cnt_q < len_q);

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            if (state_q == IDLE && state_d == START) begin
                owner_q <= pick;
                len_q   <= length_arr[pick];
            end
            if (state_q == RELEASE) rr_q <= next_ptr;
        end
    end

    always_comb begin
        state_d            = state_q;
        in_cnt_d           = in_cnt_q;
        out_cnt_d          = out_cnt_q;
        grant_o            = '0;
        job_done_o         = '0;
        req_value_ready_o  = '0;
        res_valid_o        = '0;
        res_value_o        = '0;
        srt_start_o        = 1'b0;
        srt_length_o       = '0;
        srt_value_o        = '0;
        srt_value_valid_o  = 1'b0;
        srt_sorted_ready_o = 1'b0;
        busy_o             = (state_q != IDLE);

        if (state_q != IDLE) begin
            grant_o      = owner_onehot;
            srt_length_o = len_q;
        end

        case (state_q)
            IDLE: begin
                if (pick_found && !srt_busy_i) state_d = START;
            end
            START: begin
                srt_start_o = 1'b1;
                state_d     = (len_q == '0) ? RELEASE : LOAD;
            end
            LOAD: begin
                srt_value_o                = value_arr[owner_q];
                srt_value_valid_o          = req_value_valid_i[owner_q] && in_open;
                req_value_ready_o[owner_q] = srt_value_ready_i && in_open;
                res_value_o                = srt_sorted_value_i;
                res_valid_o[owner_q]       = srt_sorted_valid_i && out_open;
                srt_sorted_ready_o         = res_ready_i[owner_q] && out_open;
                if (req_value_valid_i[owner_q] && srt_value_ready_i && in_open)
                    in_cnt_d = in_cnt_q + 1'b1;
                if (srt_sorted_valid_i && res_ready_i[owner_q] && out_open)
                    out_cnt_d = out_cnt_q + 1'b1;
                // Leave once both streams are complete, counting this cycle's handshakes.
                if (in_cnt_d == len_q && out_cnt_d == len_q) state_d = RELEASE;
            end
            RELEASE: begin
                job_done_o = owner_onehot;
                in_cnt_d   = '0;
                out_cnt_d  = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter: a routing vector table plus scripted jobs acting as
// requesters and as the shared sorter.
module tb_sort_job_arbiter;
    localparam int NUM_REQ = 2;
    localparam int VW      = 10;
    localparam int CW      = 16;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [NUM_REQ-1:0]     req_i;
    logic [NUM_REQ*CW-1:0]  req_length_i;
    logic [NUM_REQ-1:0]     grant_o;
    logic [NUM_REQ-1:0]     job_done_o;
    logic [NUM_REQ*VW-1:0]  req_value_i;
    logic [NUM_REQ-1:0]     req_value_valid_i;
    logic [NUM_REQ-1:0]     req_value_ready_o;
    logic [VW-1:0]          res_value_o;
    logic [NUM_REQ-1:0]     res_valid_o;
    logic [NUM_REQ-1:0]     res_ready_i;
    logic                   srt_start_o;
    logic [CW-1:0]          srt_length_o;
    logic [VW-1:0]          srt_value_o;
    logic                   srt_value_valid_o;
    logic                   srt_value_ready_i;
    logic [VW-1:0]          srt_sorted_value_i;
    logic                   srt_sorted_valid_i;
    logic                   srt_sorted_ready_o;
    logic                   srt_busy_i;
    logic                   busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int job_in[$];

    typedef struct {
        logic [1:0]    vvalid;
        logic [VW-1:0] val0;
        logic [VW-1:0] val1;
        logic          sready;
        logic          svalid;
        logic [VW-1:0] sval;
        logic [1:0]    rready;
        logic          exp_svv;
        logic [VW-1:0] exp_sv;
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_resv;
        logic [VW-1:0] exp_resval;
        logic          exp_ssr;
        logic [1:0]    exp_done;
    } vec_t;

    sort_job_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .VALUE_WIDTH(VW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .req_i             (req_i),
        .req_length_i      (req_length_i),
        .grant_o           (grant_o),
        .job_done_o        (job_done_o),
        .req_value_i       (req_value_i),
        .req_value_valid_i (req_value_valid_i),
        .req_value_ready_o (req_value_ready_o),
        .res_value_o       (res_value_o),
        .res_valid_o       (res_valid_o),
        .res_ready_i       (res_ready_i),
        .srt_start_o       (srt_start_o),
        .srt_length_o      (srt_length_o),
        .srt_value_o       (srt_value_o),
        .srt_value_valid_o (srt_value_valid_o),
        .srt_value_ready_i (srt_value_ready_i),
        .srt_sorted_value_i(srt_sorted_value_i),
        .srt_sorted_valid_i(srt_sorted_valid_i),
        .srt_sorted_ready_o(srt_sorted_ready_o),
        .srt_busy_i        (srt_busy_i),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_i              = '0;
        req_length_i       = '0;
        req_value_i        = '0;
        req_value_valid_i  = '0;
        res_ready_i        = '0;
        srt_value_ready_i  = 1'b0;
        srt_sorted_value_i = '0;
        srt_sorted_valid_i = 1'b0;
        srt_busy_i         = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"},        32'(grant_o),            32'h0);
        check({tag, "_job_done"},     32'(job_done_o),         32'h0);
        check({tag, "_value_ready"},  32'(req_value_ready_o),  32'h0);
        check({tag, "_res_valid"},    32'(res_valid_o),        32'h0);
        check({tag, "_srt_valid"},    32'(srt_value_valid_o),  32'h0);
        check({tag, "_sorted_ready"}, 32'(srt_sorted_ready_o), 32'h0);
        check({tag, "_start"},        32'(srt_start_o),        32'h0);
        check({tag, "_length"},       32'(srt_length_o),       32'h0);
        check({tag, "_busy"},         32'(busy_o),             32'h0);
    endtask

    // Runs one job for requester `own` with values from job_in; the bench plays the sorter,
    // which returns job_in in ascending order once all inputs have been accepted.
    task automatic run_job(input int own, input int len, input bit toggle_ready, input bit drop_req);
        int               srt[$];
        int               tmp, cyc, sorter_in, sorter_out, rcvd, exp_v;
        bit               done_seen;
        logic [NUM_REQ-1:0] one;
        one = NUM_REQ'(1 << own);
        srt = job_in;
        for (int a = 0; a < srt.size(); a++)
            for (int b = 0; b + 1 < srt.size() - a; b++)
                if (srt[b] > srt[b+1]) begin
                    tmp = srt[b]; srt[b] = srt[b+1]; srt[b+1] = tmp;
                end

        cyc = 0;
        #1;
        while (grant_o == '0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("job_grant_start", 32'(grant_o), 32'(one));
        check("job_start_pulse", 32'(srt_start_o), 32'h1);
        check("job_length", 32'(srt_length_o), 32'(len));
        if (drop_req) req_i = '0;
        step();

        sorter_in = 0; sorter_out = 0; rcvd = 0; done_seen = 1'b0; cyc = 0;
        while (!done_seen && cyc < 200) begin
            req_value_valid_i = '1;
            req_value_i       = '0;
            if (sorter_in < len) req_value_i[own*VW +: VW] = VW'(job_in[sorter_in]);
            else                 req_value_i[own*VW +: VW] = '1;
            srt_value_ready_i  = 1'b1;
            srt_sorted_valid_i = (sorter_in == len);
            if (sorter_out < len) srt_sorted_value_i = VW'(srt[sorter_out]);
            else                  srt_sorted_value_i = '1;
            res_ready_i = toggle_ready ? {NUM_REQ{(cyc % 2) == 0}} : '1;
            #1;
            check("job_grant_held", 32'(grant_o), 32'(one));
            check("job_nonowner_quiet", 32'({res_valid_o & ~one, req_value_ready_o & ~one}), 32'h0);
            if (cyc == 0) check("job_start_one_cycle", 32'(srt_start_o), 32'h0);
            if (srt_value_valid_o && srt_value_ready_i) begin
                exp_v = (sorter_in < len) ? job_in[sorter_in] : 32'hDEAD;
                check("job_srt_value", 32'(srt_value_o), exp_v);
                sorter_in++;
            end
            if (srt_sorted_valid_i && srt_sorted_ready_o) sorter_out++;
            if ((res_valid_o & res_ready_i & one) != '0) begin
                exp_v = (rcvd < len) ? srt[rcvd] : 32'hDEAD;
                check("job_res_value", 32'(res_value_o), exp_v);
                rcvd++;
            end
            if (job_done_o != '0) begin
                done_seen = 1'b1;
                check("job_done_owner", 32'(job_done_o), 32'(one));
                check("job_length_held", 32'(srt_length_o), 32'(len));
            end
            step();
            cyc++;
        end
        check("job_done_seen", 32'(done_seen), 32'h1);
        check("job_in_count", sorter_in, len);
        check("job_sorter_out_count", sorter_out, len);
        check("job_res_count", rcvd, len);
        req_value_valid_i  = '0;
        srt_value_ready_i  = 1'b0;
        srt_sorted_valid_i = 1'b0;
        res_ready_i        = '0;
        #1;
        check("job_grant_dropped", 32'(grant_o), 32'h0);
        check("job_done_pulse_end", 32'(job_done_o), 32'h0);
    endtask

    initial begin
        vec_t vecs [6];
        // Owner 1, length 2: routing, gating by counters, surplus refusal, then RELEASE.
        vecs[0] = '{2'b01, 10'd11, 10'd22, 1'b1, 1'b0, 10'd0, 2'b00,
                    1'b0, 10'd22, 2'b10, 2'b00, 10'd0, 1'b0, 2'b00};
        vecs[1] = '{2'b10, 10'd11, 10'd33, 1'b0, 1'b0, 10'd0, 2'b00,
                    1'b1, 10'd33, 2'b00, 2'b00, 10'd0, 1'b0, 2'b00};
        vecs[2] = '{2'b11, 10'd11, 10'd44, 1'b1, 1'b1, 10'd7, 2'b01,
                    1'b1, 10'd44, 2'b10, 2'b10, 10'd7, 1'b0, 2'b00};
        vecs[3] = '{2'b10, 10'd11, 10'd55, 1'b1, 1'b1, 10'd8, 2'b10,
                    1'b1, 10'd55, 2'b10, 2'b10, 10'd8, 1'b1, 2'b00};
        vecs[4] = '{2'b10, 10'd11, 10'd66, 1'b1, 1'b1, 10'd9, 2'b11,
                    1'b0, 10'd66, 2'b00, 2'b10, 10'd9, 1'b1, 2'b00};
        vecs[5] = '{2'b11, 10'd11, 10'd77, 1'b1, 1'b1, 10'd3, 2'b11,
                    1'b0, 10'd0, 2'b00, 2'b00, 10'd0, 1'b0, 2'b10};

        // Reset with every input active: outputs must stay quiet.
        reset_i            = 1'b1;
        req_i              = '1;
        req_length_i       = '1;
        req_value_i        = '1;
        req_value_valid_i  = '1;
        res_ready_i        = '1;
        srt_value_ready_i  = 1'b1;
        srt_sorted_value_i = '1;
        srt_sorted_valid_i = 1'b1;
        srt_busy_i         = 1'b0;
        step();
        step();
        check_zero_outputs("reset");
        reset_i = 1'b0;
        clear_inputs();

        // Vector table on a length-2 job owned by requester 1.
        req_length_i = {16'd2, 16'd0};
        req_i        = 2'b10;
        step();
        check("tbl_start", 32'(srt_start_o), 32'h1);
        check("tbl_grant_start", 32'(grant_o), 32'h2);
        req_i = '0;
        step();
        for (int r = 0; r < 6; r++) begin
            req_value_valid_i  = vecs[r].vvalid;
            req_value_i        = {vecs[r].val1, vecs[r].val0};
            srt_value_ready_i  = vecs[r].sready;
            srt_sorted_valid_i = vecs[r].svalid;
            srt_sorted_value_i = vecs[r].sval;
            res_ready_i        = vecs[r].rready;
            #1;
            check($sformatf("tbl%0d_grant", r), 32'(grant_o), 32'h2);
            check($sformatf("tbl%0d_srt_valid", r), 32'(srt_value_valid_o), 32'(vecs[r].exp_svv));
            if (vecs[r].exp_svv)
                check($sformatf("tbl%0d_srt_value", r), 32'(srt_value_o), 32'(vecs[r].exp_sv));
            check($sformatf("tbl%0d_value_ready", r), 32'(req_value_ready_o), 32'(vecs[r].exp_rdy));
            check($sformatf("tbl%0d_res_valid", r), 32'(res_valid_o), 32'(vecs[r].exp_resv));
            if (vecs[r].exp_resv != '0)
                check($sformatf("tbl%0d_res_value", r), 32'(res_value_o), 32'(vecs[r].exp_resval));
            check($sformatf("tbl%0d_sorted_ready", r), 32'(srt_sorted_ready_o), 32'(vecs[r].exp_ssr));
            check($sformatf("tbl%0d_job_done", r), 32'(job_done_o), 32'(vecs[r].exp_done));
            step();
        end
        check("tbl_grant_released", 32'(grant_o), 32'h0);
        clear_inputs();

        // Requester 0 alone, values 5,1,3; request dropped mid-job.
        job_in       = '{5, 1, 3};
        req_length_i = {16'd0, 16'd3};
        req_i        = 2'b01;
        run_job(0, 3, 1'b0, 1'b1);

        // Zero-length job from requester 1.
        job_in       = {};
        req_length_i = {16'd0, 16'd0};
        req_i        = 2'b10;
        run_job(1, 0, 1'b0, 1'b1);

        // Both requesting with pointer at 0: 01, 10, 01.
        req_length_i = {16'd2, 16'd2};
        req_i        = 2'b11;
        job_in       = '{7, 2};
        run_job(0, 2, 1'b0, 1'b0);
        job_in       = '{0, 9};
        run_job(1, 2, 1'b0, 1'b0);
        job_in       = '{4, 4};
        run_job(0, 2, 1'b0, 1'b1);

        // Owner's result ready toggling every cycle, length 8.
        req_length_i = {16'd0, 16'd8};
        req_i        = 2'b01;
        job_in       = '{8, 3, 6, 1, 7, 2, 5, 4};
        run_job(0, 8, 1'b1, 1'b1);

        // Sorter busy blocks the grant until it falls.
        srt_busy_i   = 1'b1;
        req_length_i = {16'd0, 16'd1};
        req_i        = 2'b01;
        for (int c = 0; c < 4; c++) begin
            step();
            check("busy_blocks_grant", 32'(grant_o), 32'h0);
        end
        srt_busy_i = 1'b0;
        #1;
        check("busy_fall_same_cycle", 32'(grant_o), 32'h0);
        step();
        check("grant_after_busy", 32'(grant_o), 32'h1);
        job_in = '{5};
        run_job(0, 1, 1'b0, 1'b1);

        // Reset in the middle of LOAD, then a fresh length-1 job.
        req_length_i = {16'd0, 16'd4};
        req_i        = 2'b01;
        step();
        check("midreset_start_grant", 32'(grant_o), 32'h1);
        step();
        req_value_valid_i  = 2'b01;
        req_value_i        = {10'd0, 10'd3};
        srt_value_ready_i  = 1'b1;
        srt_sorted_valid_i = 1'b1;
        res_ready_i        = 2'b11;
        #1;
        check("midreset_load_valid", 32'(srt_value_valid_o), 32'h1);
        reset_i = 1'b1;
        step();
        check_zero_outputs("midreset");
        reset_i = 1'b0;
        clear_inputs();
        req_length_i = {16'd0, 16'd1};
        req_i        = 2'b01;
        job_in       = '{6};
        run_job(0, 1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
